// File: rtl/ser_pkg.sv
// Shared definitions for the serializer / deserializer pair.
package ser_pkg;

   // Shifter occupancy: IDLE = shifter empty, SHIFT = shifter loaded.
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_e;

   // Bit-counter width able to hold 0..w, i.e. ceil(log2(w+1)), min 1.
   function automatic int ser_cnt_w(input int w);
      return (w < 1) ? 1 : $clog2(w + 1);
   endfunction

endpackage

// File: rtl/p2s_hold_reg.sv
// One-entry holding register with full flag; parks the next word while
// the shifter is still draining the current one.
module p2s_hold_reg #(
   parameter int width = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_wr,
   input  logic             i_rd,
   input  logic [width-1:0] i_data,
   output logic             o_full,
   output logic [width-1:0] o_data
);

   logic             r_full;
   logic [width-1:0] r_data;

   // Full flag: set on write, cleared when the shifter takes the word.
   // Writes only happen while empty and reads only while full, so the
   // two never coincide.
   always_ff @(posedge clk) begin
      if (rst)        r_full <= 1'b0;
      else if (i_wr)  r_full <= 1'b1;
      else if (i_rd)  r_full <= 1'b0;
   end

   // Data capture; contents are meaningless while the flag is clear.
   always_ff @(posedge clk) begin
      if (rst)        r_data <= '0;
      else if (i_wr)  r_data <= i_data;
   end

   assign o_full = r_full;
   assign o_data = r_data;

endmodule

// File: rtl/parallel_to_serial.sv
// Parallel-to-serial converter: one shifter plus one holding register,
// LSB first, valid/ready on both sides, one bit per cycle sustained.
module parallel_to_serial
   import ser_pkg::*;
#(
   parameter int width = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             parallel_valid,
   input  logic [width-1:0] parallel_data,
   output logic             parallel_ready,
   input  logic             serial_ready,
   output logic             serial_valid,
   output logic             serial_data,
   output logic             serial_last,
   output logic             busy
);

   localparam int             CW            = ser_cnt_w(width);
   localparam logic [CW-1:0]  LAST_IDX      = CW'(width - 1);
   // A one-bit word is its own last bit as soon as it is loaded.
   localparam logic           LAST_ON_LOAD  = (width == 1);

   ser_state_e       r_state;
   logic [width-1:0] r_shift;
   logic [CW-1:0]    r_cnt;
   logic             r_last;

   logic             w_hold_full;
   logic [width-1:0] w_hold_data;
   logic             w_shifting;
   logic             w_word_xfer;
   logic             w_bit_xfer;
   logic             w_final;
   logic             w_hold_wr;
   logic             w_hold_rd;
   logic             w_load_direct;
   logic [CW-1:0]    w_cnt_nxt;

   // Handshake decode. Ready depends only on the hold flag, so there is
   // no combinational path from either valid or serial_ready to it.
   assign w_shifting    = (r_state == SHIFT);
   assign w_word_xfer   = parallel_valid & ~w_hold_full;
   assign w_bit_xfer    = w_shifting & serial_ready;
   assign w_final       = w_bit_xfer & r_last;
   // On the final-bit edge a parked word wins; ready is low then anyway.
   assign w_hold_rd     = w_final & w_hold_full;
   assign w_load_direct = w_word_xfer & (~w_shifting | w_final);
   assign w_hold_wr     = w_word_xfer & w_shifting & ~w_final;
   assign w_cnt_nxt     = r_cnt + 1'b1;

   p2s_hold_reg #(
      .width (width)
   ) u_hold (
      .clk    (clk),
      .rst    (rst),
      .i_wr   (w_hold_wr),
      .i_rd   (w_hold_rd),
      .i_data (parallel_data),
      .o_full (w_hold_full),
      .o_data (w_hold_data)
   );

   // Shifter FSM: load, shift right on each accepted bit, reload or idle
   // on the final bit. The counter only wraps through a reload.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_cnt   <= '0;
         r_last  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_load_direct) begin
                  r_state <= SHIFT;
                  r_shift <= parallel_data;
                  r_cnt   <= '0;
                  r_last  <= LAST_ON_LOAD;
               end
            end
            SHIFT: begin
               if (w_hold_rd) begin
                  r_shift <= w_hold_data;
                  r_cnt   <= '0;
                  r_last  <= LAST_ON_LOAD;
               end else if (w_final && w_load_direct) begin
                  r_shift <= parallel_data;
                  r_cnt   <= '0;
                  r_last  <= LAST_ON_LOAD;
               end else if (w_final) begin
                  // Clearing the shifter keeps serial_data at 0 in IDLE.
                  r_state <= IDLE;
                  r_shift <= '0;
                  r_cnt   <= '0;
                  r_last  <= 1'b0;
               end else if (w_bit_xfer) begin
                  r_shift <= r_shift >> 1;
                  r_cnt   <= w_cnt_nxt;
                  r_last  <= (w_cnt_nxt == LAST_IDX);
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Outputs come straight from state; gated to 0 when not valid.
   assign parallel_ready = ~w_hold_full;
   assign serial_valid   = w_shifting;
   assign serial_data    = w_shifting & r_shift[0];
   assign serial_last    = w_shifting & r_last;
   assign busy           = w_shifting | w_hold_full;

endmodule

// File: tb/tb_parallel_to_serial.sv
// Bench for parallel_to_serial: width=8 instance plus a width=1 instance.
module tb_parallel_to_serial;

   logic       clk = 1'b0;
   logic       rst;
   always #5 clk = ~clk;

   logic       pv, pr, sr, sv, sd, sl, busy;
   logic [7:0] pd;
   logic       q_pv, q_pr, q_sr, q_sv, q_sd, q_sl, q_busy;
   logic [0:0] q_pd;

   parallel_to_serial #(.width(8)) dut (
      .clk(clk), .rst(rst),
      .parallel_valid(pv), .parallel_data(pd), .parallel_ready(pr),
      .serial_ready(sr), .serial_valid(sv), .serial_data(sd),
      .serial_last(sl), .busy(busy)
   );

   parallel_to_serial #(.width(1)) dut1 (
      .clk(clk), .rst(rst),
      .parallel_valid(q_pv), .parallel_data(q_pd), .parallel_ready(q_pr),
      .serial_ready(q_sr), .serial_valid(q_sv), .serial_data(q_sd),
      .serial_last(q_sl), .busy(q_busy)
   );

   int checks   = 0;
   int failures = 0;

   // Loopback receiver: rebuilds words from accepted bits (LSB first) and
   // tallies protocol violations seen on the serial side.
   logic [7:0] rx_q[$];
   logic [7:0] acc;
   int         bitpos   = 0;
   int         zero_err = 0;
   int         stab_err = 0;
   int         last_err = 0;
   logic       stall = 1'b0, psd = 1'b0, psl = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         bitpos = 0;
         stall  = 1'b0;
      end else begin
         if (!sv && (sd || sl)) zero_err++;
         if (stall && !(sv && sd == psd && sl == psl)) stab_err++;
         if (sv && sr) begin
            acc[bitpos] = sd;
            if (sl !== (bitpos == 7)) last_err++;
            if (bitpos == 7) begin
               rx_q.push_back(acc);
               bitpos = 0;
            end else begin
               bitpos++;
            end
         end
         stall = sv && !sr;
         psd   = sd;
         psl   = sl;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; pv = 1'b1; pd = 8'h5A; sr = 1'b1;
      q_pv = 1'b1; q_pd = 1'b1; q_sr = 1'b1;
      step(); step();
      @(negedge clk);
      checks++; if (pr !== 1'b1)   begin failures++; $display("FAIL reset_pready got=%b exp=1", pr); end
      checks++; if (sv !== 1'b0)   begin failures++; $display("FAIL reset_svalid got=%b exp=0", sv); end
      checks++; if (sd !== 1'b0)   begin failures++; $display("FAIL reset_sdata got=%b exp=0", sd); end
      checks++; if (sl !== 1'b0)   begin failures++; $display("FAIL reset_slast got=%b exp=0", sl); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (q_sv !== 1'b0 || q_pr !== 1'b1) begin failures++; $display("FAIL reset_w1 got sv=%b pr=%b exp sv=0 pr=1", q_sv, q_pr); end
      step();
      rst = 1'b0; pv = 1'b0; q_pv = 1'b0;
      @(negedge clk);
      checks++; if (sv !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_ignored got sv=%b busy=%b exp 0 0", sv, busy); end
      step();
   endtask

   task automatic test_single();
      logic [7:0] w;
      w = 8'hA5;
      pv = 1'b1; pd = w; sr = 1'b1;
      @(negedge clk);
      checks++; if (pr !== 1'b1) begin failures++; $display("FAIL single_pready got=%b exp=1", pr); end
      step();
      pv = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++;
         if (sv !== 1'b1 || sd !== w[i] || sl !== (i == 7)) begin
            failures++;
            $display("FAIL single_bit%0d got v=%b d=%b l=%b exp v=1 d=%b l=%b", i, sv, sd, sl, w[i], (i == 7));
         end
         step();
      end
      @(negedge clk);
      checks++; if (sv !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_idle got sv=%b busy=%b exp 0 0", sv, busy); end
      step();
   endtask

   task automatic test_back_to_back();
      logic [15:0] stream;
      logic        exp_pr;
      stream = {8'hFF, 8'h01};
      pv = 1'b1; pd = 8'h01; sr = 1'b1;
      @(negedge clk);
      step();
      pd = 8'hFF;
      for (int k = 0; k < 16; k++) begin
         exp_pr = (k == 0) || (k >= 8);
         @(negedge clk);
         checks++;
         if (sv !== 1'b1 || sd !== stream[k] || sl !== (k % 8 == 7) || pr !== exp_pr) begin
            failures++;
            $display("FAIL b2b_bit%0d got v=%b d=%b l=%b pr=%b exp v=1 d=%b l=%b pr=%b",
                     k, sv, sd, sl, pr, stream[k], (k % 8 == 7), exp_pr);
         end
         step();
         if (k == 0) pv = 1'b0;
      end
      @(negedge clk);
      checks++; if (sv !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got sv=%b busy=%b exp 0 0", sv, busy); end
      step();
   endtask

   task automatic test_backpressure();
      logic exp_b[8];
      logic got[$];
      logic fd, fl;
      int   se0;
      exp_b = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      fd = 1'b0; fl = 1'b0;
      se0 = stab_err;
      pv = 1'b1; pd = 8'h3C; sr = 1'b1;
      @(negedge clk);
      step();
      pv = 1'b0;
      for (int c = 0; c < 20; c++) begin
         sr = !(c >= 3 && c < 8);
         @(negedge clk);
         if (c == 3) begin
            fd = sd; fl = sl;
         end else if (c > 3 && c < 8) begin
            checks++;
            if (sv !== 1'b1 || sd !== fd || sl !== fl) begin
               failures++;
               $display("FAIL bp_frozen_c%0d got v=%b d=%b l=%b exp v=1 d=%b l=%b", c, sv, sd, sl, fd, fl);
            end
         end
         if (sv && sr) got.push_back(sd);
         step();
      end
      sr = 1'b1;
      checks++; if (got.size() != 8) begin failures++; $display("FAIL bp_count got=%0d exp=8", got.size()); end
      for (int i = 0; i < 8 && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp_b[i]) begin failures++; $display("FAIL bp_bit%0d got=%b exp=%b", i, got[i], exp_b[i]); end
      end
      checks++; if (stab_err != se0) begin failures++; $display("FAIL bp_stability got=%0d exp=%0d", stab_err, se0); end
   endtask

   task automatic test_reset_mid();
      int   n0;
      logic quiet;
      n0 = rx_q.size();
      pv = 1'b1; pd = 8'hF0; sr = 1'b1;
      @(negedge clk);
      step();
      pd = 8'h0F;
      @(negedge clk);
      checks++; if (pr !== 1'b1) begin failures++; $display("FAIL rmid_pready got=%b exp=1", pr); end
      step();
      pv = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         step();
      end
      rst = 1'b1; pv = 1'b1; pd = 8'hAA;
      @(negedge clk);
      checks++; if (sv !== 1'b1 || sd !== 1'b0 || pr !== 1'b0) begin failures++; $display("FAIL rmid_bit3 got v=%b d=%b pr=%b exp 1 0 0", sv, sd, pr); end
      step();
      @(negedge clk);
      checks++;
      if (pr !== 1'b1 || sv !== 1'b0 || sd !== 1'b0 || sl !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL rmid_reset got pr=%b v=%b d=%b l=%b busy=%b exp 1 0 0 0 0", pr, sv, sd, sl, busy);
      end
      step();
      rst = 1'b0; pv = 1'b0;
      quiet = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (sv !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
         step();
      end
      checks++; if (quiet !== 1'b1) begin failures++; $display("FAIL rmid_quiet got=%b exp=1", quiet); end
      checks++; if (rx_q.size() != n0) begin failures++; $display("FAIL rmid_words got=%0d exp=%0d", rx_q.size(), n0); end
   endtask

   task automatic test_width1();
      logic w1[3];
      w1 = '{1'b1, 1'b0, 1'b1};
      q_sr = 1'b1; q_pv = 1'b1; q_pd = w1[0];
      @(negedge clk);
      step();
      for (int i = 0; i < 3; i++) begin
         if (i < 2) q_pd = w1[i+1];
         else       q_pv = 1'b0;
         @(negedge clk);
         checks++;
         if (q_sv !== 1'b1 || q_sd !== w1[i] || q_sl !== 1'b1 || q_pr !== 1'b1) begin
            failures++;
            $display("FAIL w1_bit%0d got v=%b d=%b l=%b pr=%b exp v=1 d=%b l=1 pr=1", i, q_sv, q_sd, q_sl, q_pr, w1[i]);
         end
         step();
      end
      @(negedge clk);
      checks++; if (q_sv !== 1'b0 || q_busy !== 1'b0) begin failures++; $display("FAIL w1_idle got sv=%b busy=%b exp 0 0", q_sv, q_busy); end
      step();
   endtask

   task automatic test_random_loopback();
      logic [7:0] sent_q[$];
      int         base, cyc, ze0, se0, le0, wait_c;
      logic       acc_now;
      base = rx_q.size();
      ze0 = zero_err; se0 = stab_err; le0 = last_err;
      pv = 1'b0; cyc = 0;
      while (sent_q.size() < 100 && cyc < 6000) begin
         if (!pv && $urandom_range(0, 3) != 0) begin
            pv = 1'b1;
            pd = 8'($urandom);
         end
         sr = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         acc_now = pv && pr;
         if (acc_now) sent_q.push_back(pd);
         step();
         if (acc_now) pv = 1'b0;
         cyc++;
      end
      pv = 1'b0; sr = 1'b1;
      wait_c = 0;
      @(negedge clk);
      while (busy && wait_c < 100) begin
         step();
         @(negedge clk);
         wait_c++;
      end
      step();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rnd_drain got busy=%b exp=0", busy); end
      checks++; if (sent_q.size() != 100) begin failures++; $display("FAIL rnd_sent got=%0d exp=100", sent_q.size()); end
      checks++; if (rx_q.size() - base != sent_q.size()) begin failures++; $display("FAIL rnd_rcvd got=%0d exp=%0d", rx_q.size() - base, sent_q.size()); end
      for (int i = 0; i < sent_q.size() && base + i < rx_q.size(); i++) begin
         checks++;
         if (rx_q[base+i] !== sent_q[i]) begin failures++; $display("FAIL rnd_word%0d got=%h exp=%h", i, rx_q[base+i], sent_q[i]); end
      end
      checks++; if (zero_err != ze0) begin failures++; $display("FAIL rnd_zero_when_invalid got=%0d exp=%0d", zero_err, ze0); end
      checks++; if (stab_err != se0) begin failures++; $display("FAIL rnd_stable got=%0d exp=%0d", stab_err, se0); end
      checks++; if (last_err != le0) begin failures++; $display("FAIL rnd_last got=%0d exp=%0d", last_err, le0); end
   endtask

   initial begin
      rst = 1'b1; pv = 1'b0; pd = '0; sr = 1'b1;
      q_pv = 1'b0; q_pd = '0; q_sr = 1'b1;
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_width1();
      test_random_loopback();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
